// File: rtl/dti_fifo_wptr_ctrl.sv
// ----------------------------------------------------------------------------
// dti_fifo_wptr_ctrl
// Write-side pointer controller for the dti_fifo dual-clock FIFO. It lives
// entirely in the write clock domain. It gates producer writes into the RAM,
// keeps the binary and Gray write pointers, and decodes the synchronised Gray
// read pointer. From these it derives full, almost_full, the fill level and
// the overflow status. All status is conservative: a stale read pointer can
// only make the FIFO look fuller than it really is, never emptier.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// dti_fifo_gray2bin
// Library Gray-to-binary converter. Purely combinational.
// ----------------------------------------------------------------------------
module dti_fifo_gray2bin #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   logic [WIDTH-1:0] bin_s;
   logic             acc_s;

   // Running XOR from the MSB down: bin[i] = ^gray[WIDTH-1:i]
   always_comb begin
      bin_s = {WIDTH{1'b0}};
      acc_s = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc_s    = acc_s ^ gray[i];
         bin_s[i] = acc_s;
      end
   end

   assign bin = bin_s;

endmodule

// ----------------------------------------------------------------------------
// dti_fifo_wptr_ctrl
// ----------------------------------------------------------------------------
module dti_fifo_wptr_ctrl #(
   parameter int ADDR_WIDTH   = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH:0]   rd_gptr_sync,
   input  logic                  ovf_clr,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [ADDR_WIDTH:0]   wr_gptr,
   output logic                  full,
   output logic                  almost_full,
   output logic [ADDR_WIDTH:0]   wr_level,
   output logic                  overflow,
   output logic                  ovf_sticky
);

   // Pointer width: one extra bit to tell full from empty.
   localparam int PW = ADDR_WIDTH + 1;

   // Threshold sized to the level width so the compare is width-clean.
   localparam logic [PW-1:0] AFULL_THRESH_C = PW'(AFULL_THRESH);

   // Binary to Gray: adjacent codes differ in exactly one bit, which is what
   // makes the pointer safe to pass through a multi-bit synchroniser.
   function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Full pattern in Gray space: two MSBs inverted, remaining bits equal.
   // This is the Gray image of (read pointer + depth).
   function automatic logic [PW-1:0] full_pattern(input logic [PW-1:0] g);
      logic [PW-1:0] p;
      p = g;
      p[PW-1] = ~g[PW-1];
      p[PW-2] = ~g[PW-2];
      return p;
   endfunction

   // Registered state
   logic [PW-1:0]         wbin_r;
   logic [ADDR_WIDTH-1:0] wr_addr_r;
   logic [PW-1:0]         wr_gptr_r;
   logic                  full_r;
   logic                  almost_full_r;
   logic [PW-1:0]         wr_level_r;
   logic                  overflow_r;
   logic                  ovf_sticky_r;

   // Combinational next-state
   logic                  wr_en_s;
   logic [PW-1:0]         wbin_next_s;
   logic [PW-1:0]         wgray_next_s;
   logic [PW-1:0]         rbin_s;
   logic [PW-1:0]         level_next_s;
   logic                  full_next_s;
   logic                  almost_full_next_s;
   logic                  ovf_set_s;
   logic                  ovf_sticky_next_s;

   // Read pointer decode, combinational from the already synchronised value.
   dti_fifo_gray2bin #(
      .WIDTH (PW)
   ) u_rptr_g2b (
      .gray (rd_gptr_sync),
      .bin  (rbin_s)
   );

   // Write gating: a write is accepted only while the registered full is low,
   // so a refused write leaves both pointers untouched.
   assign wr_en_s = wr_req & ~full_r;

   // Next pointer, Gray image, level and flag computation.
   always_comb begin
      wbin_next_s        = wbin_r + {{ADDR_WIDTH{1'b0}}, wr_en_s};
      wgray_next_s       = bin2gray(wbin_next_s);
      full_next_s        = (wgray_next_s == full_pattern(rd_gptr_sync));
      level_next_s       = wbin_next_s - rbin_s;
      almost_full_next_s = (level_next_s >= AFULL_THRESH_C);
   end

   // Sticky overflow next value; a set in the same cycle as a clear wins.
   always_comb begin
      ovf_set_s = wr_req & full_r;
      if (ovf_set_s) begin
         ovf_sticky_next_s = 1'b1;
      end else if (ovf_clr) begin
         ovf_sticky_next_s = 1'b0;
      end else begin
         ovf_sticky_next_s = ovf_sticky_r;
      end
   end

   // Pointer and status registers, cleared asynchronously by rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin_r        <= {PW{1'b0}};
         wr_addr_r     <= {ADDR_WIDTH{1'b0}};
         wr_gptr_r     <= {PW{1'b0}};
         full_r        <= 1'b0;
         almost_full_r <= 1'b0;
         wr_level_r    <= {PW{1'b0}};
      end else begin
         wbin_r        <= wbin_next_s;
         wr_addr_r     <= wbin_next_s[ADDR_WIDTH-1:0];
         wr_gptr_r     <= wgray_next_s;
         full_r        <= full_next_s;
         almost_full_r <= almost_full_next_s;
         wr_level_r    <= level_next_s;
      end
   end

   // Overflow pulse and sticky flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r   <= 1'b0;
         ovf_sticky_r <= 1'b0;
      end else begin
         overflow_r   <= ovf_set_s;
         ovf_sticky_r <= ovf_sticky_next_s;
      end
   end

   assign wr_en       = wr_en_s;
   assign wr_addr     = wr_addr_r;
   assign wr_gptr     = wr_gptr_r;
   assign full        = full_r;
   assign almost_full = almost_full_r;
   assign wr_level    = wr_level_r;
   assign overflow    = overflow_r;
   assign ovf_sticky  = ovf_sticky_r;

endmodule

// File: tb/tb_dti_fifo_wptr_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dti_fifo_wptr_ctrl
// Directed self-checking bench for the write-side pointer controller,
// ADDR_WIDTH=4, AFULL_THRESH=12.
// ----------------------------------------------------------------------------
module tb_dti_fifo_wptr_ctrl;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_req;
   logic [AW:0]   rd_gptr_sync;
   logic          ovf_clr;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW:0]   wr_gptr;
   logic          full;
   logic          almost_full;
   logic [AW:0]   wr_level;
   logic          overflow;
   logic          ovf_sticky;

   int n_tests = 0;
   int n_fail  = 0;

   dti_fifo_wptr_ctrl #(
      .ADDR_WIDTH   (4),
      .AFULL_THRESH (12)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_req       (wr_req),
      .rd_gptr_sync (rd_gptr_sync),
      .ovf_clr      (ovf_clr),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_gptr      (wr_gptr),
      .full         (full),
      .almost_full  (almost_full),
      .wr_level     (wr_level),
      .overflow     (overflow),
      .ovf_sticky   (ovf_sticky)
   );

   // Free-running write clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [AW:0] gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   // Advance one clock; sample 1 unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_wr_en"},       32'(wr_en),       32'd0);
      check_val({tag, "_wr_addr"},     32'(wr_addr),     32'd0);
      check_val({tag, "_wr_gptr"},     32'(wr_gptr),     32'd0);
      check_val({tag, "_full"},        32'(full),        32'd0);
      check_val({tag, "_almost_full"}, 32'(almost_full), 32'd0);
      check_val({tag, "_wr_level"},    32'(wr_level),    32'd0);
      check_val({tag, "_overflow"},    32'(overflow),    32'd0);
      check_val({tag, "_ovf_sticky"},  32'(ovf_sticky),  32'd0);
   endtask

   logic [AW:0] exp_wbin;
   logic [AW:0] prev_gptr;
   logic        wrapped;

   initial begin
      rst          = 1'b1;
      wr_req       = 1'b0;
      ovf_clr      = 1'b0;
      rd_gptr_sync = 5'b00000;
      step();
      step();
      rst = 1'b0;

      // ---------------- Reset: async assert mid-cycle ----------------
      wr_req = 1'b1;
      step();
      step();
      wr_req = 1'b0;
      check_val("pre_reset_wr_addr", 32'(wr_addr), 32'd2);
      check_val("pre_reset_wr_gptr", 32'(wr_gptr), 32'd3);
      #3;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      rst = 1'b0;
      step();
      step();
      check_all_zero("post_reset_idle");

      // ---------------- Fill: 16 writes with rd pointer at 0 ----------------
      for (int k = 1; k <= 16; k++) begin
         wr_req = 1'b1;
         #0;
         check_val($sformatf("fill_wr_en_%0d", k), 32'(wr_en), 32'd1);
         step();
         check_val($sformatf("fill_gptr_%0d", k),  32'(wr_gptr), 32'(gray(5'(k))));
         check_val($sformatf("fill_level_%0d", k), 32'(wr_level), 32'(k));
         check_val($sformatf("fill_afull_%0d", k), 32'(almost_full), (k >= 12) ? 32'd1 : 32'd0);
         check_val($sformatf("fill_full_%0d", k),  32'(full), (k == 16) ? 32'd1 : 32'd0);
      end
      check_val("fill_final_gptr",  32'(wr_gptr),  32'd24);
      check_val("fill_final_level", 32'(wr_level), 32'd16);

      // ---------------- Overflow ----------------
      #0;
      check_val("ovf_wr_en_blocked", 32'(wr_en), 32'd0);
      step();
      wr_req = 1'b0;
      check_val("ovf_pulse",       32'(overflow),   32'd1);
      check_val("ovf_sticky_set",  32'(ovf_sticky), 32'd1);
      check_val("ovf_gptr_hold",   32'(wr_gptr),    32'd24);
      check_val("ovf_addr_hold",   32'(wr_addr),    32'd0);
      check_val("ovf_level_hold",  32'(wr_level),   32'd16);
      check_val("ovf_full_hold",   32'(full),       32'd1);
      step();
      check_val("ovf_pulse_end",   32'(overflow),   32'd0);
      check_val("ovf_sticky_keep", 32'(ovf_sticky), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check_val("ovf_sticky_clr",  32'(ovf_sticky), 32'd0);
      check_val("ovf_full_still",  32'(full),       32'd1);

      // ---------------- Release: read pointer jumps to binary 8 ----------------
      rd_gptr_sync = 5'b01100;
      step();
      check_val("rel_full",  32'(full),        32'd0);
      check_val("rel_afull", 32'(almost_full), 32'd0);
      check_val("rel_level", 32'(wr_level),    32'd8);
      check_val("rel_gptr",  32'(wr_gptr),     32'd24);

      // ---------------- Wrap-around with reader trailing by 3 ----------------
      rst = 1'b1;
      step();
      rst          = 1'b0;
      rd_gptr_sync = 5'b00000;
      wr_req       = 1'b1;
      repeat (3) step();
      exp_wbin = 5'd3;
      check_val("wrap_start_level", 32'(wr_level), 32'd3);
      check_val("wrap_start_gptr",  32'(wr_gptr),  32'd2);
      prev_gptr = wr_gptr;
      wrapped   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rd_gptr_sync = gray(exp_wbin - 5'd2);
         step();
         exp_wbin = exp_wbin + 5'd1;
         if (exp_wbin == 5'd0) wrapped = 1'b1;
         check_val($sformatf("wrap_gptr_%0d", i),  32'(wr_gptr), 32'(gray(exp_wbin)));
         check_val($sformatf("wrap_hamm_%0d", i),  32'($countones(wr_gptr ^ prev_gptr)), 32'd1);
         check_val($sformatf("wrap_level_%0d", i), 32'(wr_level), 32'd3);
         check_val($sformatf("wrap_full_%0d", i),  32'(full), 32'd0);
         check_val($sformatf("wrap_addr_%0d", i),  32'(wr_addr), 32'(exp_wbin[AW-1:0]));
         prev_gptr = wr_gptr;
      end
      check_val("wrap_seen",     32'(wrapped), 32'd1);
      check_val("wrap_end_gptr", 32'(wr_gptr), 32'(gray(5'd11)));

      // ---------------- Simultaneous write and read at level 15 ----------------
      // Read pointer stays at binary 8; 12 more writes take level 3 -> 15.
      repeat (12) step();
      check_val("sim_pre_level", 32'(wr_level),    32'd15);
      check_val("sim_pre_afull", 32'(almost_full), 32'd1);
      check_val("sim_pre_full",  32'(full),        32'd0);
      rd_gptr_sync = 5'b01101;
      #0;
      check_val("sim_wr_en", 32'(wr_en), 32'd1);
      step();
      wr_req = 1'b0;
      check_val("sim_level", 32'(wr_level), 32'd15);
      check_val("sim_full",  32'(full),     32'd0);
      check_val("sim_gptr",  32'(wr_gptr),  32'b10100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Hard time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1);
   end

endmodule

// File: doc/dti_fifo_wptr_ctrl.md
# dti_fifo_wptr_ctrl

Write-side pointer controller for the dual-clock FIFO in the dti_fifo library. It runs entirely in the write clock domain and does the following:
- Accepts write requests and gates them into the FIFO RAM write enable.
- Maintains the binary and Gray-coded write pointers.
- Decodes the externally synchronised Gray read pointer back to binary, then derives full, almost-full, fill level and overflow status.

It pairs with the read-side controller and the 2-flop pointer synchronisers in the FIFO top level.

## Interface
- ADDR_WIDTH, 4, RAM address bits; FIFO depth is 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 12, fill level at or above which almost_full is asserted; legal range 1..2**ADDR_WIDTH.

Ports:
- clk  in  1  write-domain clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- wr_req  in  1  write request from the producer, one word per cycle.
- rd_gptr_sync  in  ADDR_WIDTH+1  Gray read pointer, already synchronised into clk.
- ovf_clr  in  1  clears the sticky overflow flag.
- wr_en  out  1  RAM write enable; combinational, wr_req & ~full.
- wr_addr  out  ADDR_WIDTH  RAM write address; low ADDR_WIDTH bits of the binary write pointer, registered.
- wr_gptr  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-side synchroniser.
- full  out  1  registered; FIFO full.
- almost_full  out  1  registered; level >= AFULL_THRESH.
- wr_level  out  ADDR_WIDTH+1  registered conservative fill level, 0..2**ADDR_WIDTH.
- overflow  out  1  one-cycle pulse, registered, when wr_req arrives while full.
- ovf_sticky  out  1  sticky overflow flag.

## Operation
- **Internal state:** wbin is the binary write pointer, ADDR_WIDTH+1 bits, registered.
- **Next pointer:**
  - wbin_next = wbin + wr_en, wrapping modulo 2**(ADDR_WIDTH+1).
  - wgray_next = wbin_next ^ (wbin_next >> 1).
- **Read pointer decode:** rbin is the combinational Gray-to-binary decode of rd_gptr_sync, using the library converter with WIDTH = ADDR_WIDTH+1.
- **Full:** full_next is 1 when wgray_next equals rd_gptr_sync with its two MSBs inverted and the remaining bits equal.
- **Level:** level_next = (wbin_next − rbin) mod 2**(ADDR_WIDTH+1).
- **Almost-full:** almost_full_next = (level_next >= AFULL_THRESH).
- **Register update each cycle:**
  - wbin <= wbin_next
  - wr_gptr <= wgray_next
  - full <= full_next
  - wr_level <= level_next
  - almost_full <= almost_full_next
- **Overflow:**
  - overflow <= wr_req & full.
  - ovf_sticky is set by that same condition and cleared by ovf_clr.
  - If set and clear occur in the same cycle, set wins.
- **Writes when full:** a write presented while full is dropped. wr_en stays 0 and no pointer moves.
- **Conservative status:** full, level and almost_full are conservative. They release only after the read pointer update arrives through the synchroniser. Stale rd_gptr_sync values never cause overwrite.

## Timing
- **Reset:** while rst is high, asynchronously clear all of wbin, wr_addr, wr_gptr, full, almost_full, wr_level, overflow and ovf_sticky to 0.
- **Reset mid-operation:** discards all pointer state. The read side must be reset together with this block.
- **Write latency:** wr_en follows wr_req in the same cycle, gated by the current registered full. The pointer, wr_addr and wr_gptr advance on the following edge.
- **Full assertion:** the write that fills the last slot produces full=1 on the edge that retires it. A wr_req in the next cycle is refused.
- **Full release:** full deasserts on the first edge after rd_gptr_sync shows a read.
- **Simultaneous write and read-pointer change:** level accounts for both in one cycle, so level is unchanged for one write plus one read.
- **Wrap-around:** the pointer wraps from 2**(ADDR_WIDTH+1)−1 to 0 with no glitch in flags. wr_gptr changes exactly one bit per write.
- **Stability:** wr_gptr is registered and changes at most once per clk. This is required for safe synchronisation.

## Test plan
All scenarios use ADDR_WIDTH=4 and AFULL_THRESH=12.
- **Reset:** assert rst asynchronously mid-cycle -> all outputs 0 immediately. Release, with wr_req=0 -> outputs hold 0.
- **Fill:** rd_gptr_sync=0, issue 16 consecutive wr_req:
  - wr_gptr sequence 1,3,2,6,...,24.
  - almost_full=1 after the 12th write.
  - full=1 after the 16th write.
  - wr_level=16.
- **Overflow:** keep wr_req=1 while full -> wr_en=0, overflow pulses 1 cycle, ovf_sticky=1, pointers unchanged. Pulse ovf_clr -> ovf_sticky=0.
- **Release:** while full, set rd_gptr_sync=5'b01100 (binary 8) -> next edge full=0, almost_full=0, wr_level=8.
- **Wrap-around:** stream 40 writes with the read pointer trailing by 3 -> wbin wraps 31->0, full never asserts, wr_level stays 3, wr_gptr Hamming distance is 1 per write.
- **Simultaneous events:** drive wr_req together with a read-pointer increment at level 15 -> level stays 15, full stays 0.
